// File: rtl/ws2812b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_pkg
// Description : Shared pixel layout and frame-feeder FSM encoding.
// Revision    : 1.0
// ============================================================================
package ws2812b_pkg;

    localparam int PIXEL_W = 24;
    localparam int CHAN_W  = 8;
    localparam int G_LSB   = 16;
    localparam int R_LSB   = 8;
    localparam int B_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PRESENT = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/ws2812b_pixel_scale.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_pixel_scale
// Description : Combinational GRB pixel brightness scaler, out=(c*(b+1))>>8.
// Revision    : 1.0
// ============================================================================
module ws2812b_pixel_scale
    import ws2812b_pkg::*;
(
    input  logic [PIXEL_W-1:0] pixel_i,
    input  logic [7:0]         brightness_i,
    output logic [PIXEL_W-1:0] pixel_o
);

    logic [8:0] w_factor;

    // The +1 makes brightness 255 an exact identity and 0 a hard black.
    assign w_factor = {1'b0, brightness_i} + 9'd1;

    localparam int CHAN_LSB [3] = '{B_LSB, R_LSB, G_LSB};

    generate
        for (genvar ch = 0; ch < 3; ch++) begin : g_chan
            logic [16:0] w_prod;
            logic        w_unused_bits;

            assign w_prod = {9'd0, pixel_i[CHAN_LSB[ch] +: CHAN_W]} * {8'd0, w_factor};
            assign pixel_o[CHAN_LSB[ch] +: CHAN_W] = w_prod[15:8];
            assign w_unused_bits = ^{w_prod[16], w_prod[7:0]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/ws2812b_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ws2812b_frame_feeder
// Description : Reads, scales and packs one pixel per stripe for each LED.
// Revision    : 1.0
// ============================================================================
module ws2812b_frame_feeder
    import ws2812b_pkg::*;
#(
    parameter  int STRIPECOUNT = 1,
    parameter  int LEDCOUNT    = 60,
    localparam int ADDR_WIDTH  = (LEDCOUNT * STRIPECOUNT > 1) ?
                                 $clog2(LEDCOUNT * STRIPECOUNT) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start_i,
    input  logic [7:0]                     brightness_i,
    output logic                           mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0]          mem_addr_o,
    input  logic [PIXEL_W-1:0]             mem_rdata_i,
    output logic [STRIPECOUNT*PIXEL_W-1:0] bitstream_o,
    output logic                           bitstream_available_o,
    input  logic                           bitstream_read_i,
    output logic                           busy_o,
    output logic                           frame_done_o
);

    localparam int WORD_W = STRIPECOUNT * PIXEL_W;
    localparam int SLOT_W = (STRIPECOUNT > 1) ? $clog2(STRIPECOUNT) : 1;
    localparam int LED_W  = (LEDCOUNT > 1) ? $clog2(LEDCOUNT) : 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(STRIPECOUNT - 1);
    localparam logic [LED_W-1:0]  LAST_LED  = LED_W'(LEDCOUNT - 1);

    state_e                  state_q,    state_d;
    logic [LED_W-1:0]        led_q,      led_d;
    logic [SLOT_W-1:0]       slot_q,     slot_d;
    logic [7:0]              bright_q,   bright_d;
    logic                    rd_en_q,    rd_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic                    cap_q,      cap_d;
    logic [SLOT_W-1:0]       cap_slot_q, cap_slot_d;
    logic [WORD_W-1:0]       word_q,     word_d;
    logic                    avail_q,    avail_d;
    logic                    busy_q,     busy_d;
    logic                    done_q,     done_d;

    logic [PIXEL_W-1:0]      w_scaled;

    ws2812b_pixel_scale u_scale (
        .pixel_i      (mem_rdata_i),
        .brightness_i (bright_q),
        .pixel_o      (w_scaled)
    );

    always_comb begin
        state_d    = state_q;
        led_d      = led_q;
        slot_d     = slot_q;
        bright_d   = bright_q;
        rd_en_d    = 1'b0;
        addr_d     = addr_q;
        avail_d    = avail_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        word_d     = word_q;
        // RAM data lags the strobe by one cycle, so the slot travels with it.
        cap_d      = rd_en_q;
        cap_slot_d = slot_q;

        for (int s = 0; s < STRIPECOUNT; s++) begin
            if (cap_q && (int'(cap_slot_q) == s)) begin
                word_d[s*PIXEL_W +: PIXEL_W] = w_scaled;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start_i) begin
                    state_d  = ST_FETCH;
                    bright_d = brightness_i;
                    led_d    = '0;
                    slot_d   = '0;
                    rd_en_d  = 1'b1;
                    addr_d   = '0;
                    busy_d   = 1'b1;
                end
            end
            ST_FETCH: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = ST_DRAIN;
                end else begin
                    slot_d  = slot_q + SLOT_W'(1);
                    rd_en_d = 1'b1;
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_PRESENT;
                avail_d = 1'b1;
            end
            ST_PRESENT: begin
                if (bitstream_read_i) begin
                    avail_d = 1'b0;
                    if (led_q == LAST_LED) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        // Pixels are contiguous per LED, so the next LED
                        // starts right after the last address issued.
                        state_d = ST_FETCH;
                        led_d   = led_q + LED_W'(1);
                        slot_d  = '0;
                        rd_en_d = 1'b1;
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            led_q      <= '0;
            slot_q     <= '0;
            bright_q   <= '0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            cap_q      <= 1'b0;
            cap_slot_q <= '0;
            word_q     <= '0;
            avail_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            led_q      <= led_d;
            slot_q     <= slot_d;
            bright_q   <= bright_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            cap_q      <= cap_d;
            cap_slot_q <= cap_slot_d;
            word_q     <= word_d;
            avail_q    <= avail_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign mem_rd_en_o           = rd_en_q;
    assign mem_addr_o            = addr_q;
    assign bitstream_o           = word_q;
    assign bitstream_available_o = avail_q;
    assign busy_o                = busy_q;
    assign frame_done_o          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812b_frame_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws2812b_frame_feeder
// Description : Self-checking bench for the frame feeder (1- and 3-stripe).
// Revision    : 1.0
// ============================================================================
module tb_ws2812b_frame_feeder;

    localparam int SA = 1;
    localparam int LA = 3;
    localparam int SC = 3;
    localparam int LC = 4;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        fs_a, rd_a, rden_a, av_a, busy_a, done_a;
    logic [7:0]  br_a;
    logic [1:0]  addr_a;
    logic [23:0] rdata_a, bs_a;

    logic        fs_c, rd_c, rden_c, av_c, busy_c, done_c;
    logic [7:0]  br_c;
    logic [3:0]  addr_c;
    logic [23:0] rdata_c;
    logic [71:0] bs_c;

    logic [23:0] ram_a [0:3];
    logic [23:0] ram_c [0:15];
    logic [23:0] exp_a [0:2];

    ws2812b_frame_feeder #(.STRIPECOUNT(SA), .LEDCOUNT(LA)) u_dut_a (
        .clk(clk), .reset(reset), .frame_start_i(fs_a), .brightness_i(br_a),
        .mem_rd_en_o(rden_a), .mem_addr_o(addr_a), .mem_rdata_i(rdata_a),
        .bitstream_o(bs_a), .bitstream_available_o(av_a),
        .bitstream_read_i(rd_a), .busy_o(busy_a), .frame_done_o(done_a)
    );

    ws2812b_frame_feeder #(.STRIPECOUNT(SC), .LEDCOUNT(LC)) u_dut_c (
        .clk(clk), .reset(reset), .frame_start_i(fs_c), .brightness_i(br_c),
        .mem_rd_en_o(rden_c), .mem_addr_o(addr_c), .mem_rdata_i(rdata_c),
        .bitstream_o(bs_c), .bitstream_available_o(av_c),
        .bitstream_read_i(rd_c), .busy_o(busy_c), .frame_done_o(done_c)
    );

    // Synchronous RAMs; the wide one returns junk when not read.
    always @(posedge clk) if (rden_a) rdata_a <= ram_a[addr_a];
    always @(posedge clk) rdata_c <= rden_c ? ram_c[addr_c] : 24'($urandom);

    int          n_total = 0;
    int          n_bad   = 0;
    int          n_done_a = 0;
    int          n_done_c = 0;
    logic [71:0] q [$];
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;

    function automatic logic [23:0] scale(input logic [23:0] p, input logic [7:0] b);
        logic [23:0] r;
        int f;
        f = int'(b) + 1;
        for (int ch = 0; ch < 3; ch++) begin
            r[ch*8 +: 8] = 8'((int'(p[ch*8 +: 8]) * f) / 256);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model of the 3-stripe instance: a frame is the ordered list
    // of scaled words, consumed one per accepted handshake.
    task automatic mon();
        logic [71:0] w;
        chk("c_busy", 72'(busy_c), 72'(m_active));
        chk("c_done", 72'(done_c), 72'(m_done));
        if (av_c) begin
            chk("c_rden_in_present", 72'(rden_c), 72'(0));
            if (q.size() == 0) chk("c_unexpected_word", 72'(av_c), 72'(0));
            else               chk("c_word", bs_c, q[0]);
        end
        if (!m_active) chk("c_idle_quiet", 72'({rden_c, av_c}), 72'(0));
        if (done_a) n_done_a++;
        if (done_c) n_done_c++;
        m_done = 1'b0;
        if (reset) begin
            q.delete();
            m_active = 1'b0;
        end else if (!m_active) begin
            if (fs_c) begin
                for (int n = 0; n < LC; n++) begin
                    w = '0;
                    for (int s = 0; s < SC; s++) w[24*s +: 24] = scale(ram_c[n*SC+s], br_c);
                    q.push_back(w);
                end
                m_active = 1'b1;
            end
        end else if (av_c && rd_c) begin
            void'(q.pop_front());
            if (q.size() == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        mon();
        @(negedge clk);
    endtask

    task automatic wait_av_c();
        for (int k = 0; k < 200 && !av_c; k++) cyc();
        chk("c_av_timeout", 72'(av_c), 72'(1));
    endtask

    task automatic wait_av_a();
        for (int k = 0; k < 200 && !av_a; k++) cyc();
        chk("a_av_timeout", 72'(av_a), 72'(1));
    endtask

    task automatic read_c();
        rd_c = 1'b1;
        cyc();
        rd_c = 1'b0;
    endtask

    task automatic read_words_c(input int n);
        for (int k = 0; k < n; k++) begin
            wait_av_c();
            read_c();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        fs_a = 1'b0; rd_a = 1'b0; br_a = 8'd0;
        fs_c = 1'b0; rd_c = 1'b0; br_c = 8'd0;
        ram_a[0] = 24'h112233; ram_a[1] = 24'h445566;
        ram_a[2] = 24'h778899; ram_a[3] = 24'h000000;
        exp_a[0] = 24'h112233; exp_a[1] = 24'h445566; exp_a[2] = 24'h778899;
        ram_c[0] = 24'hFF8001; ram_c[1] = 24'h00FF40; ram_c[2] = 24'h808080;
        for (int i = 3; i < 16; i++) ram_c[i] = {8'(i*37), 8'(200 - i*7), 8'(i*11 + 3)};

        @(negedge clk);
        repeat (3) begin
            chk("rst_a", 72'({rden_a, addr_a, bs_a, av_a, busy_a, done_a}), 72'(0));
            chk("rst_c_word", bs_c, 72'(0));
            chk("rst_c_ctl", 72'({rden_c, addr_c, av_c, busy_c, done_c}), 72'(0));
            cyc();
        end
        reset = 1'b0;

        // Single-stripe frame at full brightness.
        br_a = 8'd255; fs_a = 1'b1;
        cyc();
        fs_a = 1'b0; br_a = 8'd0;
        for (int n = 0; n < 3; n++) begin
            wait_av_a();
            chk("a_word", 72'(bs_a), 72'(exp_a[n]));
            rd_a = 1'b1;
            cyc();
            rd_a = 1'b0;
        end
        repeat (3) cyc();
        chk("a_done_count", 72'(n_done_a), 72'(1));
        chk("a_busy_end", 72'(busy_a), 72'(0));

        // Three-stripe frame: cycle-exact latency at brightness 127.
        br_c = 8'd127; fs_c = 1'b1;
        cyc();
        fs_c = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            chk("c_lat_rden", 72'(rden_c), 72'(i <= 3));
            if (i <= 3) chk("c_lat_addr", 72'(addr_c), 72'(i - 1));
            chk("c_lat_busy", 72'(busy_c), 72'(1));
            chk("c_lat_av", 72'(av_c), 72'(i == 5));
            if (i < 5) cyc();
        end
        chk("c_b127_word", bs_c, 72'h404040_007F20_7F4000);

        // Backpressure: word must hold with no RAM traffic.
        for (int i = 0; i < 50; i++) begin
            cyc();
            chk("c_hold_av", 72'(av_c), 72'(1));
            chk("c_hold_word", bs_c, 72'h404040_007F20_7F4000);
            chk("c_hold_rden", 72'(rden_c), 72'(0));
        end

        read_c();
        chk("c_after_read_av", 72'(av_c), 72'(0));
        chk("c_after_read_rden", 72'(rden_c), 72'(1));
        chk("c_after_read_addr", 72'(addr_c), 72'(3));
        // Stray read and frame_start while fetching must be ignored.
        rd_c = 1'b1; fs_c = 1'b1; br_c = 8'd0;
        cyc();
        rd_c = 1'b0; fs_c = 1'b0;
        chk("c_fetch_addr4", 72'({rden_c, addr_c}), 72'({1'b1, 4'd4}));
        cyc();
        chk("c_fetch_addr5", 72'({rden_c, addr_c}), 72'({1'b1, 4'd5}));
        rd_c = 1'b1;
        cyc();
        rd_c = 1'b0;
        chk("c_drain_av", 72'(av_c), 72'(0));
        read_words_c(3);
        repeat (3) cyc();
        chk("c_done_count1", 72'(n_done_c), 72'(1));

        // Brightness 0 blanks every channel.
        br_c = 8'd0; fs_c = 1'b1;
        cyc();
        fs_c = 1'b0;
        wait_av_c();
        chk("c_b0_word", bs_c, 72'(0));
        read_c();
        read_words_c(3);
        repeat (3) cyc();

        // Reset during PRESENT of led 1 aborts without frame_done.
        br_c = 8'd255; fs_c = 1'b1;
        cyc();
        fs_c = 1'b0;
        wait_av_c();
        read_c();
        wait_av_c();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("c_midrst_word", bs_c, 72'(0));
        chk("c_midrst_ctl", 72'({rden_c, addr_c, av_c, busy_c, done_c}), 72'(0));
        repeat (5) cyc();
        chk("c_done_count2", 72'(n_done_c), 72'(2));

        br_c = 8'd255; fs_c = 1'b1;
        cyc();
        fs_c = 1'b0;
        wait_av_c();
        chk("c_restart_word", bs_c, 72'h808080_00FF40_FF8001);
        read_c();
        read_words_c(3);
        repeat (3) cyc();
        chk("c_done_count3", 72'(n_done_c), 72'(3));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
